// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and sizing helper for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;
  localparam logic [3:0]  ADD3_INC    = 4'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StConvert = ST_CONVERT,
    StDone    = ST_DONE
  } state_e;

  // Smallest digit count with 10^digits > 2^width, i.e. no overflow possible.
  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned lim;
    longint unsigned pow;
    int unsigned     d;
    lim = 64'd1 << width;
    pow = 64'd10;
    d   = 1;
    for (int i = 0; i < 12; i++) begin
      if (pow <= lim) begin
        pow = pow * 64'd10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Valid/ready bus for bcd_seq_converter; blank exists only with BCD_SEQ_BLANK_EN defined.
interface bcd_seq_converter_if #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 5
);
  logic [WIDTH-1:0]                      in_bin;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [bcd_pkg::BCD_DIGIT_W*DIGITS-1:0] out_bcd;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  overflow;
`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0]                     blank;
`endif

  modport master (
    output in_bin, in_valid, out_ready,
`ifdef BCD_SEQ_BLANK_EN
    input  blank,
`endif
    input  in_ready, out_bcd, out_valid, overflow
  );

  modport slave (
    input  in_bin, in_valid, out_ready,
`ifdef BCD_SEQ_BLANK_EN
    output blank,
`endif
    output in_ready, out_bcd, out_valid, overflow
  );

endinterface

// File: rtl/bcd_digit_slice.sv
// One BCD digit of the shift-and-add-3 chain: conditional +3 on the held value, then shift left.
module bcd_digit_slice
  import bcd_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   shift_i,
  input  logic                   shift_in_i,
  output logic                   shift_out_o,
`ifdef BCD_SEQ_BLANK_EN
  output logic [BCD_DIGIT_W-1:0] digit_next_o,
`endif
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  logic [BCD_DIGIT_W-1:0] digit_q, digit_d;
  logic [BCD_DIGIT_W-1:0] adj;

  always_comb begin
    adj     = (digit_q >= ADD3_THRESH) ? digit_q + ADD3_INC : digit_q;
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (shift_i) begin
      digit_d = {adj[BCD_DIGIT_W-2:0], shift_in_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign shift_out_o = adj[BCD_DIGIT_W-1];
  assign digit_o     = digit_q;
`ifdef BCD_SEQ_BLANK_EN
  assign digit_next_o = digit_d;
`endif

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Optional leading-zero blanking output enabled by defining BCD_SEQ_BLANK_EN.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 5
) (
  input logic                clk,
  input logic                reset,
  bcd_seq_converter_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0]              shift_q, shift_d;
  logic                          ovf_q, ovf_d;
  logic                          load;
  logic                          shift_en;
  logic                          last_bit;
  logic [DIGITS:0]               carry;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
`ifdef BCD_SEQ_BLANK_EN
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_next;
  logic [DIGITS-1:0]             blank_q, blank_d;
  logic                          all_zero;
`endif

  // Binary MSB enters digit 0; the bit leaving the top digit marks overflow.
  assign carry[0] = shift_q[WIDTH-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_slice u_slice (
      .clk_i       (clk),
      .rst_i       (reset),
      .clear_i     (load),
      .shift_i     (shift_en),
      .shift_in_i  (carry[i]),
      .shift_out_o (carry[i+1]),
`ifdef BCD_SEQ_BLANK_EN
      .digit_next_o(bcd_next[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
`endif
      .digit_o     (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign last_bit = (cnt_q == CntW'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ovf_d    = ovf_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          shift_d = bus.in_bin;
          ovf_d   = 1'b0;
          cnt_d   = CntW'(WIDTH);
          state_d = StConvert;
        end
      end
      StConvert: begin
        shift_en = 1'b1;
        shift_d  = shift_q << 1;
        cnt_d    = cnt_q - CntW'(1);
        if (carry[DIGITS]) ovf_d = 1'b1;
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_bcd   = bcd;
  assign bus.overflow  = ovf_q;

`ifdef BCD_SEQ_BLANK_EN
  // Captured from the final digits on the last shift so it is valid with out_valid.
  always_comb begin
    blank_d  = blank_q;
    all_zero = 1'b1;
    if (load) begin
      blank_d = '0;
    end else if (shift_en && last_bit) begin
      blank_d = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        all_zero   = all_zero & (bcd_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
        blank_d[i] = all_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Randomized self-checking bench: 14-bit/5-digit and 10-bit/3-digit converters vs decimal model.
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd_seq_converter_if #(.WIDTH(14), .DIGITS(5)) bus_a ();
  bcd_seq_converter_if #(.WIDTH(10), .DIGITS(3)) bus_b ();

  bcd_seq_converter #(.WIDTH(14), .DIGITS(5)) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  bcd_seq_converter #(.WIDTH(10), .DIGITS(3)) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b.slave)
  );

  // Decimal digits of v, packed 4 bits per digit, only the lowest 'digits' digits kept.
  function automatic logic [31:0] ref_bcd(input longint unsigned v, input int digits);
    logic [31:0]     r;
    longint unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [13:0] v, output int lat, output int busy_hi,
                       output logic [19:0] bcd, output logic ovf);
    bus_a.in_bin   = v;
    bus_a.in_valid = 1'b1;
    busy_hi = 0;
    cyc();
    lat = 1;
    bus_a.in_valid = 1'b0;
    bus_a.in_bin   = 14'($urandom_range(0, 16383));
    while (!bus_a.out_valid && lat < 200) begin
      if (bus_a.in_ready) busy_hi++;
      cyc();
      lat++;
    end
    bcd = bus_a.out_bcd;
    ovf = bus_a.overflow;
  endtask

  task automatic run_b(input logic [9:0] v, output int lat, output logic [11:0] bcd,
                       output logic ovf);
    bus_b.in_bin   = v;
    bus_b.in_valid = 1'b1;
    cyc();
    lat = 1;
    bus_b.in_valid = 1'b0;
    while (!bus_b.out_valid && lat < 200) begin
      cyc();
      lat++;
    end
    bcd = bus_b.out_bcd;
    ovf = bus_b.overflow;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    total += 5;
    if (bus_a.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", bus_a.in_ready);
    end
    if (bus_a.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus_a.out_valid);
    end
    if (bus_a.out_bcd !== 20'h0) begin
      bad++; $display("FAIL reset_out_bcd: got %h want 00000", bus_a.out_bcd);
    end
    if (bus_a.overflow !== 1'b0) begin
      bad++; $display("FAIL reset_overflow: got %b want 0", bus_a.overflow);
    end
    if (bus_b.in_ready !== 1'b1 || bus_b.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_b: got rdy=%b vld=%b want 1 0", bus_b.in_ready, bus_b.out_valid);
    end
  endtask

  task automatic test_latency();
    int lat, busy;
    logic [19:0] bcd;
    logic ovf;
    run_a(14'd9999, lat, busy, bcd, ovf);
    total += 3;
    if (lat !== 15) begin
      bad++; $display("FAIL latency_9999: got %0d edges want 15", lat);
    end
    if (bcd !== 20'h09999) begin
      bad++; $display("FAIL bcd_9999: got %h want 09999", bcd);
    end
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_9999: got %b want 0", ovf);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int lat, busy;
    logic [19:0] bcd, exp;
    logic ovf;
    logic [13:0] v;
    run_a(14'd16383, lat, busy, bcd, ovf);
    total += 3;
    if (bcd !== 20'h16383) begin
      bad++; $display("FAIL bcd_max: got %h want 16383", bcd);
    end
    if (busy !== 0) begin
      bad++; $display("FAIL busy_ready_max: got %0d cycles ready want 0", busy);
    end
    cyc();
    if (bus_a.in_ready !== 1'b1) begin
      bad++; $display("FAIL idle_after_max: got %b want 1", bus_a.in_ready);
    end
    run_a(14'd0, lat, busy, bcd, ovf);
    total += 2;
    if (bcd !== 20'h00000 || ovf !== 1'b0) begin
      bad++; $display("FAIL bcd_zero: got %h/%b want 00000/0", bcd, ovf);
    end
    if (busy !== 0) begin
      bad++; $display("FAIL busy_ready_zero: got %0d cycles ready want 0", busy);
    end
    cyc();
    for (int n = 0; n < 10; n++) begin
      v   = 14'($urandom_range(0, 16383));
      exp = 20'(ref_bcd(longint'(v), 5));
      run_a(v, lat, busy, bcd, ovf);
      total += 2;
      if (bcd !== exp || ovf !== 1'b0) begin
        bad++; $display("FAIL rand_a %0d: got %h/%b want %h/0", v, bcd, ovf, exp);
      end
      if (lat !== 15 || busy !== 0) begin
        bad++; $display("FAIL rand_a_timing %0d: got lat=%0d busy=%0d want 15 0", v, lat, busy);
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    int lat, busy;
    logic [19:0] bcd, exp;
    logic ovf;
    logic [13:0] v;
    v   = 14'($urandom_range(1, 16383));
    exp = 20'(ref_bcd(longint'(v), 5));
    bus_a.out_ready = 1'b0;
    run_a(v, lat, busy, bcd, ovf);
    total++;
    if (bcd !== exp) begin
      bad++; $display("FAIL stall_bcd %0d: got %h want %h", v, bcd, exp);
    end
    for (int n = 0; n < 20; n++) begin
      bus_a.in_valid = (n < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_a.in_bin   = 14'($urandom_range(0, 16383));
      bus_a.out_ready = 1'b0;
      cyc();
      total++;
      if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0 ||
          bus_a.out_bcd !== exp || bus_a.overflow !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc %0d: got vld=%b rdy=%b bcd=%h ovf=%b want 1 0 %h 0",
                 n, bus_a.out_valid, bus_a.in_ready, bus_a.out_bcd, bus_a.overflow, exp);
      end
    end
    bus_a.out_ready = 1'b1;
    cyc();
    total += 2;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release: got vld=%b rdy=%b want 0 1",
                      bus_a.out_valid, bus_a.in_ready);
    end
    if (bus_a.out_bcd !== exp) begin
      bad++; $display("FAIL stall_keep_bcd: got %h want %h", bus_a.out_bcd, exp);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [11:0] bcd, exp;
    logic ovf;
    logic [9:0] v;
    run_b(10'd1023, lat, bcd, ovf);
    total += 3;
    if (bcd !== 12'h023 || ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_1023: got %h/%b want 023/1", bcd, ovf);
    end
    if (lat !== 11) begin
      bad++; $display("FAIL latency_b: got %0d edges want 11", lat);
    end
    run_b(10'd999, lat, bcd, ovf);
    if (bcd !== 12'h999 || ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear_999: got %h/%b want 999/0", bcd, ovf);
    end
    for (int n = 0; n < 10; n++) begin
      v   = 10'($urandom_range(900, 1023));
      exp = 12'(ref_bcd(longint'(v), 3));
      run_b(v, lat, bcd, ovf);
      total++;
      if (bcd !== exp || ovf !== (v >= 10'd1000)) begin
        bad++; $display("FAIL rand_b %0d: got %h/%b want %h/%b", v, bcd, ovf, exp, v >= 10'd1000);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy;
    logic [19:0] bcd;
    logic ovf;
    bus_a.in_bin   = 14'd4321;
    bus_a.in_valid = 1'b1;
    cyc();
    bus_a.in_valid = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total += 2;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_state: got vld=%b rdy=%b want 0 1",
                      bus_a.out_valid, bus_a.in_ready);
    end
    if (bus_a.out_bcd !== 20'h0 || bus_a.overflow !== 1'b0) begin
      bad++; $display("FAIL midreset_bcd: got %h/%b want 00000/0", bus_a.out_bcd, bus_a.overflow);
    end
    run_a(14'd42, lat, busy, bcd, ovf);
    total++;
    if (bcd !== 20'h00042 || lat !== 15) begin
      bad++; $display("FAIL after_reset_42: got %h lat=%0d want 00042 lat=15", bcd, lat);
    end
    cyc();
  endtask

`ifdef BCD_SEQ_BLANK_EN
  task automatic test_blank();
    int lat, busy;
    logic [19:0] bcd;
    logic ovf;
    logic [13:0] v;
    logic [4:0] exp_blank;
    longint unsigned p;
    for (int n = 0; n < 8; n++) begin
      v = (n == 0) ? 14'd42 : (n == 1) ? 14'd0 : 14'($urandom_range(0, 16383) >> $urandom_range(0, 13));
      // Digit i and above are all zero exactly when v < 10^i.
      exp_blank = '0;
      p = 10;
      for (int i = 1; i < 5; i++) begin
        exp_blank[i] = (longint'(v) < p);
        p = p * 10;
      end
      run_a(v, lat, busy, bcd, ovf);
      total += 2;
      if (bus_a.blank !== exp_blank) begin
        bad++; $display("FAIL blank %0d: got %b want %b", v, bus_a.blank, exp_blank);
      end
      if (bcd !== 20'(ref_bcd(longint'(v), 5))) begin
        bad++; $display("FAIL blank_bcd %0d: got %h want %h", v, bcd, 20'(ref_bcd(longint'(v), 5)));
      end
      cyc();
    end
  endtask
`endif

  initial begin
    reset           = 1'b1;
    bus_a.in_bin    = '0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_bin    = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid();
`ifdef BCD_SEQ_BLANK_EN
    test_blank();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
